gpc15_3_acc: RTL and testbench

GPC15_3_ACC -- requirements
Module: gpc15_3_acc

---
 rtl/gpc_pkg.sv | 14 +
 rtl/gpc15_3.sv | 15 +
 rtl/gpc15_3_acc.sv | 129 ++++++++++++
 tb/tb_gpc15_3_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpc_pkg.sv
// Shared definitions for the 15:3 generalized parallel counter and its frame accumulator.
// Holds the compressor port widths and the output-buffer FSM state encoding.
package gpc_pkg;

   localparam int GPC_SRC0_W = 5;
   localparam int GPC_SRC1_W = 1;
   localparam int GPC_DST_W  = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/gpc15_3.sv
// (1,5):3 generalized parallel counter: five weight-1 bits and one weight-2 bit
// compress into a 3-bit binary count, dst = popcount(src0) + 2*src1.
module gpc15_3
   import gpc_pkg::*;
(
   input  logic [GPC_SRC0_W-1:0] src0,
   input  logic [GPC_SRC1_W-1:0] src1,
   output logic [GPC_DST_W-1:0]  dst
);

   // Maximum is 5 + 2 = 7, so the 3-bit result never wraps.
   assign dst = {2'b00, src0[0]} + {2'b00, src0[1]} + {2'b00, src0[2]}
              + {2'b00, src0[3]} + {2'b00, src0[4]} + {1'b0, src1, 1'b0};

endmodule

// File: rtl/gpc15_3_acc.sv
// Streaming frame accumulator: each beat is compressed by gpc15_3, registered in S1,
// then summed per frame in S2 with saturation; results sit in a one-deep output buffer.
module gpc15_3_acc
   import gpc_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [GPC_SRC0_W-1:0] in_src0,
   input  logic [GPC_SRC1_W-1:0] in_src1,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_sum,
   output logic [CNT_W-1:0]      out_beats,
   output logic                  out_ovf
);

   logic [GPC_DST_W-1:0] beat_dst;

   logic                 s1_valid;
   logic                 s1_last;
   logic [GPC_DST_W-1:0] s1_dst;

   logic [ACC_W-1:0]     acc;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf;

   out_state_t           state;
   out_state_t           state_next;

   logic                 s1_retire;
   logic                 last_retire;
   logic                 accept;
   logic [ACC_W:0]       acc_sum;
   logic [ACC_W-1:0]     sat_sum;
   logic [CNT_W-1:0]     cnt_inc;
   logic                 ovf_next;

   gpc15_3 u_gpc (
      .src0 (in_src0),
      .src1 (in_src1),
      .dst  (beat_dst)
   );

   // A last beat cannot retire into a full buffer that nobody is draining;
   // non-last beats only touch the accumulator and always retire.
   assign s1_retire   = s1_valid && !(s1_last && out_valid && !out_ready);
   assign last_retire = s1_retire && s1_last;
   assign in_ready    = !s1_valid || s1_retire;
   assign accept      = in_valid && in_ready;

   // One spare carry bit detects the overflow that forces saturation.
   assign acc_sum  = {1'b0, acc} + {{(ACC_W-GPC_DST_W+1){1'b0}}, s1_dst};
   assign sat_sum  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   assign ovf_next = ovf || acc_sum[ACC_W];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_dst   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_last  <= in_last;
         s1_dst   <= beat_dst;
      end else if (s1_retire) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (last_retire) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (s1_retire) begin
         acc <= sat_sum;
         cnt <= cnt_inc;
         ovf <= ovf_next;
      end
   end

   // Result registers only load on a last-beat retire, so they hold steady
   // for as long as the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sum   <= '0;
         out_beats <= '0;
         out_ovf   <= 1'b0;
      end else if (last_retire) begin
         out_sum   <= sat_sum;
         out_beats <= cnt_inc;
         out_ovf   <= ovf_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // NOTE: the default assignment up front keeps this block free of latches
   // on any path that does not explicitly set state_next.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: if (last_retire) state_next = FULL;
         FULL:  if (out_ready && !last_retire) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state == FULL);
   end

endmodule

// File: tb/tb_gpc15_3_acc.sv
// Directed bench for gpc15_3_acc: a default-width instance plus an ACC_W=4 instance
// sharing the same stimulus, used for the saturation scenario.
module tb_gpc15_3_acc;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_src0;
   logic       in_src1;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [15:0] out_sum;
   logic [7:0]  out_beats;
   logic        out_ovf;

   logic        n_in_ready;
   logic        n_out_valid;
   logic [3:0]  n_out_sum;
   logic [7:0]  n_out_beats;
   logic        n_out_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   gpc15_3_acc dut (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_src0 (in_src0), .in_src1 (in_src1), .in_last (in_last),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_sum (out_sum), .out_beats (out_beats), .out_ovf (out_ovf)
   );

   gpc15_3_acc #(.ACC_W(4), .CNT_W(8)) dut_narrow (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (n_in_ready),
      .in_src0 (in_src0), .in_src1 (in_src1), .in_last (in_last),
      .out_valid (n_out_valid), .out_ready (out_ready),
      .out_sum (n_out_sum), .out_beats (n_out_beats), .out_ovf (n_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called one time unit after a rising edge; returns one unit after the accepting edge.
   task automatic send_beat(input logic [4:0] s0, input logic s1, input logic last);
      int waited = 0;
      in_src0  = s0;
      in_src1  = s1;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_frame(input logic [15:0] e_sum, input logic [7:0] e_beats,
                               input logic e_ovf, input bit narrow, input string name);
      int waited = 0;
      logic        v;
      logic [15:0] s;
      logic [7:0]  b;
      logic        o;
      v = narrow ? n_out_valid : out_valid;
      while (!v && waited < 20) begin
         @(posedge clk); #1;
         waited++;
         v = narrow ? n_out_valid : out_valid;
      end
      s = narrow ? {12'h000, n_out_sum} : out_sum;
      b = narrow ? n_out_beats : out_beats;
      o = narrow ? n_out_ovf : out_ovf;
      n_tests++;
      if (!v) begin
         n_fail++;
         $display("FAIL %s: out_valid never rose within %0d cycles", name, waited);
      end else if ({s, b, o} !== {e_sum, e_beats, e_ovf}) begin
         n_fail++;
         $display("FAIL %s: got sum=%0d beats=%0d ovf=%0b, required sum=%0d beats=%0d ovf=%0b",
                  name, s, b, o, e_sum, e_beats, e_ovf);
      end
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_sum, out_beats, out_ovf, in_ready} !== {1'b0, 16'd0, 8'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%0b sum=%0d beats=%0d ovf=%0b ready=%0b, required 0 0 0 0 1",
                  out_valid, out_sum, out_beats, out_ovf, in_ready);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%0b valid=%0b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_single_beat();
      send_beat(5'h1f, 1'b1, 1'b1);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency_early: out_valid=%0b one edge after accept, required 0", out_valid);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: out_valid=%0b two edges after accept, required 1", out_valid);
      end
      expect_frame(16'd7, 8'd1, 1'b0, 1'b0, "single_beat");
   endtask

   task automatic test_multi_beat();
      send_beat(5'h03, 1'b0, 1'b0);
      send_beat(5'h00, 1'b1, 1'b0);
      // Idle gap with junk on the data inputs must not disturb the frame.
      in_src0 = 5'h1f;
      in_src1 = 1'b1;
      in_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_last = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_gap: out_valid=%0b during idle, required 0", out_valid);
      end
      send_beat(5'h15, 1'b0, 1'b0);
      send_beat(5'h1f, 1'b1, 1'b1);
      expect_frame(16'd14, 8'd4, 1'b0, 1'b0, "four_beats");
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send_beat(5'h1f, 1'b1, 1'b1);
      expect_frame(16'd7, 8'd1, 1'b0, 1'b0, "b2b_frame1_arrive");
      send_beat(5'h03, 1'b0, 1'b0);
      send_beat(5'h15, 1'b0, 1'b1);
      n_tests++;
      if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 16'd7}) begin
         n_fail++;
         $display("FAIL b2b_stall: got ready=%0b valid=%0b sum=%0d, required 0 1 7",
                  in_ready, out_valid, out_sum);
      end
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, out_sum, out_beats} !== {1'b0, 1'b1, 16'd7, 8'd1}) begin
         n_fail++;
         $display("FAIL b2b_hold: got ready=%0b valid=%0b sum=%0d beats=%0d, required 0 1 7 1",
                  in_ready, out_valid, out_sum, out_beats);
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if ({in_ready, out_sum} !== {1'b1, 16'd7}) begin
         n_fail++;
         $display("FAIL b2b_release: got ready=%0b sum=%0d, required 1 7", in_ready, out_sum);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, out_sum, out_beats} !== {1'b1, 16'd5, 8'd2}) begin
         n_fail++;
         $display("FAIL b2b_frame2: got valid=%0b sum=%0d beats=%0d, required 1 5 2",
                  out_valid, out_sum, out_beats);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: out_valid=%0b, required 0", out_valid);
      end
   endtask

   task automatic test_overflow();
      send_beat(5'h1f, 1'b1, 1'b0);
      send_beat(5'h1f, 1'b1, 1'b0);
      send_beat(5'h1f, 1'b1, 1'b1);
      expect_frame(16'd15, 8'd3, 1'b1, 1'b1, "ovf_narrow");
      send_beat(5'h01, 1'b0, 1'b1);
      expect_frame(16'd1, 8'd1, 1'b0, 1'b1, "ovf_cleared");
   endtask

   task automatic test_beat_saturation();
      for (int i = 0; i < 299; i++) send_beat(5'h00, 1'b0, 1'b0);
      send_beat(5'h01, 1'b0, 1'b1);
      expect_frame(16'd1, 8'd255, 1'b0, 1'b0, "beat_count_sat");
   endtask

   task automatic test_reset_mid_frame();
      send_beat(5'h1f, 1'b1, 1'b0);
      send_beat(5'h1f, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_sum, out_beats, in_ready} !== {1'b0, 16'd0, 8'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_clear: got valid=%0b sum=%0d beats=%0d ready=%0b, required 0 0 0 1",
                  out_valid, out_sum, out_beats, in_ready);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(5'h07, 1'b1, 1'b1);
      expect_frame(16'd5, 8'd1, 1'b0, 1'b0, "reset_mid_frame");
   endtask

   task automatic test_sweep();
      logic [5:0] code;
      logic [15:0] e_sum;
      for (int c = 0; c < 64; c++) begin
         code  = 6'(c);
         e_sum = 16'($countones(code[4:0])) + (code[5] ? 16'd2 : 16'd0);
         send_beat(code[4:0], code[5], 1'b1);
         expect_frame(e_sum, 8'd1, 1'b0, 1'b0, $sformatf("sweep_%02h", code));
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_src0   = 5'h00;
      in_src1   = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #2;
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_back_to_back();
      test_overflow();
      test_beat_saturation();
      test_reset_mid_frame();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
